ram_program_loader: RTL and testbench

- Write-side counterpart to the CPU datapath's read-only RAM port. The datapath only fetches from RAM, with its write enable tied low.
- Accepts a framed byte stream from a host byte source (e.g. a UART receiver) over a valid/ready handshake and assembles 16-bit words.
- Writes each word into RAM through a single-cycle write strobe.
- Holds the CPU (cpu_hold, ORed into the CPU reset) for the whole load. Releases it only after a successful load.

---
 rtl/ram_program_loader.sv | 140 ++++++++++++++
 tb/tb_ram_program_loader.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ram_program_loader.sv
// ram_program_loader: assembles a framed byte stream into 16-bit RAM writes while holding the CPU in reset.
// Optional trailing XOR checksum byte is enabled with `define LOADER_CHECKSUM_EN.
module ram_program_loader #(
  parameter int ADDR_W        = 16,
  parameter int BASE_ADDR     = 0,
  parameter int MAX_WORDS     = 1024,
  parameter bit HOLD_AT_RESET = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [15:0]       ram_data,
  output logic              ram_wren,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] words_loaded
);
  typedef enum logic [3:0] {
    IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, DONE, ERROR
`ifdef LOADER_CHECKSUM_EN
    , CHECK
`endif
  } state_t;
`ifdef LOADER_CHECKSUM_EN
  localparam state_t FIN = CHECK;
`else
  localparam state_t FIN = DONE;
`endif
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  state_t state_q, state_d;
  logic [15:0] len_q, len_d, data_q, data_d;
  logic [7:0] hi_q, hi_d;
  logic [ADDR_W-1:0] addr_q, addr_d, words_q, words_d;
  logic hold_q, hold_d, xfer, idle_like;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;
`endif
  assign idle_like = state_q inside {IDLE, DONE, ERROR};
  assign xfer = rx_valid & rx_ready;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    data_d  = data_q;
    addr_d  = addr_q;
    words_d = words_q;
    hold_d  = hold_q;
`ifdef LOADER_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    if (idle_like && start) begin
      state_d = LEN_HI;
      hold_d  = 1'b1;
      words_d = '0;
      addr_d  = BASE;
`ifdef LOADER_CHECKSUM_EN
      csum_d  = '0;
`endif
    end else if (xfer) begin
      case (state_q)
        LEN_HI: begin
          len_d[15:8] = rx_data;
          state_d     = LEN_LO;
        end
        LEN_LO: begin
          len_d[7:0] = rx_data;
          state_d    = ({len_q[15:8], rx_data} == 16'd0) ? FIN :
                       ({16'd0, len_q[15:8], rx_data} > 32'(MAX_WORDS)) ? ERROR : DATA_HI;
        end
        DATA_HI: begin
          hi_d    = rx_data;
          state_d = DATA_LO;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
        end
        DATA_LO: begin
          data_d  = {hi_q, rx_data};
          state_d = WRITE;
`ifdef LOADER_CHECKSUM_EN
          csum_d  = csum_q ^ rx_data;
`endif
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: state_d = (rx_data == csum_q) ? DONE : ERROR;
`endif
        default: ;
      endcase
    end else if (state_q == WRITE) begin
      words_d = words_q + ADDR_W'(1);
      addr_d  = addr_q + ADDR_W'(1);
      state_d = (words_d == ADDR_W'(len_q)) ? FIN : DATA_HI;
    end
    if (state_d == DONE) hold_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      data_q  <= '0;
      addr_q  <= BASE;
      words_q <= '0;
      hold_q  <= HOLD_AT_RESET;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      hold_q  <= hold_d;
`ifdef LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end
`ifdef LOADER_CHECKSUM_EN
  assign rx_ready = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
`else
  assign rx_ready = state_q inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO};
`endif
  assign ram_wren     = state_q == WRITE;
  assign busy         = !idle_like;
  assign done         = state_q == DONE;
  assign error        = state_q == ERROR;
  assign cpu_hold     = hold_q;
  assign words_loaded = words_q;
  assign ram_addr     = addr_q;
  assign ram_data     = data_q;
endmodule

// File: tb/tb_ram_program_loader.sv
// tb_ram_program_loader: scoreboard bench; expected RAM writes are queued by stimulus and popped by a write monitor.
module tb_ram_program_loader;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic rx_ready, ram_wren, cpu_hold, busy, done, error;
  logic [15:0] ram_addr, ram_data, words_loaded;
  int cmp_cnt = 0, err_cnt = 0;
  logic [31:0] exp_q[$];
  always #5 clk = ~clk;
  ram_program_loader dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_addr(ram_addr), .ram_data(ram_data), .ram_wren(ram_wren),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error), .words_loaded(words_loaded)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (ram_wren) begin
      if (exp_q.size() == 0) chk("unexpected_wren", {ram_addr, ram_data}, 32'hxxxxxxxx);
      else chk("ram_write", {ram_addr, ram_data}, exp_q.pop_front());
      chk("rx_ready_in_write", {31'd0, rx_ready}, 32'd0);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask
  task automatic send(input logic [7:0] b, input int gap);
    int n = 0;
    repeat (gap) tick();
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 50) begin
      tick();
      n++;
    end
    if (!rx_ready) chk("rx_ready_timeout", 32'd0, 32'd1);
    tick();
    rx_valid = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    if (busy) chk("busy_timeout", 32'd1, 32'd0);
  endtask
  task automatic status(input string name, input logic d, input logic e, input logic h, input logic [15:0] w);
    chk({name, "_done"}, {31'd0, done}, {31'd0, d});
    chk({name, "_error"}, {31'd0, error}, {31'd0, e});
    chk({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, h});
    chk({name, "_words"}, {16'd0, words_loaded}, {16'd0, w});
  endtask
  task automatic push3();
    exp_q.push_back({16'd0, 16'h1234});
    exp_q.push_back({16'd1, 16'hABCD});
    exp_q.push_back({16'd2, 16'h0001});
  endtask
  logic [7:0] frame [8] = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01};
  int gaps [8] = '{2, 0, 3, 1, 0, 4, 2, 1};
  initial begin
    repeat (2) tick();
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("rst_wren", {31'd0, ram_wren}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_addr", {16'd0, ram_addr}, 32'd0);
    status("rst", 1'b0, 1'b0, 1'b0, 16'd0);
    rst = 1'b0;
    tick();
    pulse_start();
    chk("start_hold", {31'd0, cpu_hold}, 32'd1);
    chk("start_busy", {31'd0, busy}, 32'd1);
    push3();
    foreach (frame[i]) send(frame[i], 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h41, 0);
`endif
    wait_idle();
    status("normal", 1'b1, 1'b0, 1'b0, 16'd3);
    chk("normal_drain", exp_q.size(), 32'd0);
    pulse_start();
    chk("restart_done_clr", {31'd0, done}, 32'd0);
    push3();
    foreach (frame[i]) send(frame[i], gaps[i]);
`ifdef LOADER_CHECKSUM_EN
    send(8'h41, 3);
`endif
    wait_idle();
    status("gaps", 1'b1, 1'b0, 1'b0, 16'd3);
    chk("gaps_drain", exp_q.size(), 32'd0);
    pulse_start();
    send(8'h00, 0);
    send(8'h00, 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h00, 0);
`endif
    status("n0", 1'b1, 1'b0, 1'b0, 16'd0);
    pulse_start();
    send(8'h04, 0);
    send(8'h01, 0);
    status("toolong", 1'b0, 1'b1, 1'b1, 16'd0);
    chk("toolong_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    exp_q.push_back({16'd0, 16'h1234});
    send(8'h00, 0);
    send(8'h02, 0);
    send(8'h12, 0);
    send(8'h34, 0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    status("midrst", 1'b0, 1'b0, 1'b0, 16'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_addr", {16'd0, ram_addr}, 32'd0);
    pulse_start();
    send(8'h00, 0);
    send(8'h01, 0);
    pulse_start();
    chk("ign_start_ready", {31'd0, rx_ready}, 32'd1);
    chk("ign_start_busy", {31'd0, busy}, 32'd1);
    exp_q.push_back({16'd0, 16'hABCD});
    send(8'hAB, 0);
    send(8'hCD, 0);
`ifdef LOADER_CHECKSUM_EN
    send(8'h66, 0);
`endif
    wait_idle();
    status("ign_start", 1'b1, 1'b0, 1'b0, 16'd1);
`ifdef LOADER_CHECKSUM_EN
    pulse_start();
    push3();
    foreach (frame[i]) send(frame[i], 0);
    send(8'h42, 0);
    wait_idle();
    status("badsum", 1'b0, 1'b1, 1'b1, 16'd3);
`endif
    repeat (3) tick();
    chk("final_drain", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
